// File: rtl/peripheral_spi.sv
// SPI master (mode 0, 8-bit, MSB first) on the J1 I/O bus: tx/rx/status/div/ctrl registers.
// Build option SPI_LOOPBACK_EN: MISO is taken from the internal MOSI instead of the spi_miso pin.
module peripheral_spi #(
    parameter int unsigned clk_freq    = 25000000,
    parameter logic [7:0]  default_div = 8'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss_n
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t     r_state, w_state_nx;
    logic       r_busy, w_busy_nx;
    logic       r_ovr, w_ovr_nx;
    logic [7:0] r_rx, w_rx_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [7:0] r_div, w_div_nx;
    logic       r_ss_en, w_ss_en_nx;
    logic       r_sck, w_sck_nx;
    logic       r_mosi, w_mosi_nx;
    logic [2:0] r_bit, w_bit_nx;
    logic [7:0] r_cnt, w_cnt_nx;

    logic w_miso;
    logic w_unused;
    logic w_tick;
    logic w_wr_tx, w_wr_div, w_wr_ctrl, w_rd_stat;

`ifdef SPI_LOOPBACK_EN
    assign w_miso   = r_mosi;
    assign w_unused = &{1'b0, d_in[15:8], spi_miso, clk_freq[0]};
`else
    assign w_miso   = spi_miso;
    assign w_unused = &{1'b0, d_in[15:8], clk_freq[0]};
`endif

    assign w_wr_tx   = cs && wr && (addr == 4'h0);
    assign w_wr_div  = cs && wr && (addr == 4'h6);
    assign w_wr_ctrl = cs && wr && (addr == 4'h8);
    assign w_rd_stat = cs && rd && (addr == 4'h4);

    // Each SCK phase lasts div+1 clocks; the counter wraps when it reaches div.
    assign w_tick = (r_cnt == r_div);

    always_comb begin
        w_state_nx = r_state;
        w_busy_nx  = r_busy;
        w_rx_nx    = r_rx;
        w_shift_nx = r_shift;
        w_sck_nx   = r_sck;
        w_mosi_nx  = r_mosi;
        w_bit_nx   = r_bit;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_wr_tx) begin
                    w_shift_nx = d_in[7:0];
                    w_bit_nx   = 3'd0;
                    w_cnt_nx   = 8'd0;
                    w_busy_nx  = 1'b1;
                    w_mosi_nx  = d_in[7];
                    w_state_nx = S_LOW;
                end
            end
            S_LOW: begin
                w_sck_nx = 1'b0;
                if (w_tick) begin
                    // Received bit enters at the LSB; the tx bits move up and out of [7].
                    w_cnt_nx   = 8'd0;
                    w_sck_nx   = 1'b1;
                    w_shift_nx = {r_shift[6:0], w_miso};
                    w_state_nx = S_HIGH;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_HIGH: begin
                w_sck_nx = 1'b1;
                if (w_tick) begin
                    w_cnt_nx = 8'd0;
                    w_sck_nx = 1'b0;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_mosi_nx  = r_shift[7];
                        w_bit_nx   = r_bit + 3'd1;
                        w_state_nx = S_LOW;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_rx_nx    = r_shift;
                w_busy_nx  = 1'b0;
                w_sck_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // A colliding start sets overrun even when the status read would clear it.
    always_comb begin
        w_ovr_nx = r_ovr;
        if (w_wr_tx && r_busy)
            w_ovr_nx = 1'b1;
        else if (w_rd_stat)
            w_ovr_nx = 1'b0;
        w_div_nx = r_div;
        if (w_wr_div && !r_busy)
            w_div_nx = d_in[7:0];
        w_ss_en_nx = r_ss_en;
        if (w_wr_ctrl)
            w_ss_en_nx = d_in[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_rx    <= 8'h00;
            r_shift <= 8'h00;
            r_div   <= default_div;
            r_ss_en <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_bit   <= 3'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= w_busy_nx;
            r_ovr   <= w_ovr_nx;
            r_rx    <= w_rx_nx;
            r_shift <= w_shift_nx;
            r_div   <= w_div_nx;
            r_ss_en <= w_ss_en_nx;
            r_sck   <= w_sck_nx;
            r_mosi  <= w_mosi_nx;
            r_bit   <= w_bit_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        d_out = 16'h0000;
        if (cs && rd) begin
            case (addr)
                4'h2:    d_out = {8'h00, r_rx};
                4'h4:    d_out = {14'b0, r_ovr, r_busy};
                4'h6:    d_out = {8'h00, r_div};
                4'h8:    d_out = {15'b0, r_ss_en};
                default: d_out = 16'h0000;
            endcase
        end
    end

    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_ss_n = ~r_ss_en;

endmodule

// File: tb/tb_peripheral_spi.sv
// Randomized scoreboard bench for peripheral_spi: a register/transfer model predicts every bus read
// and every MOSI byte; independent monitors compare what the DUT presents.
module tb_peripheral_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = 16'h0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = 4'h0;
    wire  [15:0] d_out;
    wire         spi_sck, spi_mosi, spi_ss_n;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] v;
        logic        ss_n;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int         ph = 0;
    int         busy_end = -1;
    logic [7:0] m_div = 8'd12;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] pend_rx = 8'h00;
    bit         pend = 1'b0;
    bit         m_ss = 1'b0;
    bit         m_ovr = 1'b0;
    logic [7:0] nxt_slv = 8'h00;
    logic [7:0] slv_cur = 8'h00;

    // slave side: byte shifted out MSB first, advanced after every SCK rise
    logic [2:0] bit_i = 3'd0;
    logic [7:0] frame = 8'h00;
    wire        spi_miso = slv_cur[~bit_i];

    peripheral_spi dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ss_n(spi_ss_n)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endfunction

    // One bus phase: model predicts, inputs are driven, one clock edge passes.
    task automatic bus(input bit c, input bit r, input bit w, input logic [3:0] a, input logic [15:0] d);
        rd_exp_t e;
        bit b;
        if (pend && ph > busy_end) begin
            m_rx = pend_rx;
            pend = 1'b0;
        end
        b = (ph <= busy_end);
        cs = c; rd = r; wr = w; addr = a; d_in = d;
        if (c && r) begin
            e.a = a;
            e.ss_n = ~m_ss;
            case (a)
                4'h2:    e.v = {8'h00, m_rx};
                4'h4:    e.v = {14'h0, m_ovr, b};
                4'h6:    e.v = {8'h00, m_div};
                4'h8:    e.v = {15'h0, m_ss};
                default: e.v = 16'h0000;
            endcase
            rd_q.push_back(e);
            if (a == 4'h4) m_ovr = 1'b0;
        end
        if (c && w) begin
            case (a)
                4'h0: begin
                    if (b) m_ovr = 1'b1;
                    else begin
                        slv_cur = nxt_slv;
                        tx_q.push_back(d[7:0]);
`ifdef SPI_LOOPBACK_EN
                        pend_rx = d[7:0];
`else
                        pend_rx = nxt_slv;
`endif
                        pend = 1'b1;
                        busy_end = ph + 16 * (int'(m_div) + 1) + 1;
                    end
                end
                4'h6: if (!b) m_div = d[7:0];
                4'h8: m_ss = d[0];
                default: ;
            endcase
        end
        @(posedge clk); #1; ph++;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(0, 0, 0, 4'h0, 16'h0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        chk("rst_sck", {15'h0, spi_sck}, 16'h0);
        chk("rst_mosi", {15'h0, spi_mosi}, 16'h0);
        chk("rst_ss_n", {15'h0, spi_ss_n}, 16'h1);
        chk("rst_d_out", d_out, 16'h0);
        busy_end = -1; pend = 1'b0; m_rx = 8'h00; m_div = 8'd12; m_ss = 1'b0; m_ovr = 1'b0;
        tx_q.delete();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1; ph++;
        end
        rst = 1'b0;
    endtask

    // MOSI frame monitor
    initial forever begin
        @(posedge spi_sck or posedge rst);
        if (rst) begin
            bit_i = 3'd0;
            frame = 8'h00;
        end else begin
            frame = {frame[6:0], spi_mosi};
            bit_i = bit_i + 3'd1;
            if (bit_i == 3'd0) begin
                if (tx_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL mosi_frame: got unexpected byte %h, none required", frame);
                end else chk("mosi_frame", {8'h00, frame}, {8'h00, tx_q.pop_front()});
            end
        end
    end

    // Bus read monitor
    initial forever begin
        @(negedge clk);
        if (cs && rd) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got %h with no prediction", d_out);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk($sformatf("rd_addr%h", e.a), d_out, e.v);
                chk("ss_n", {15'h0, spi_ss_n}, {15'h0, e.ss_n});
            end
        end
    end

    initial begin
        logic [3:0] ua;
        do_reset(3);
        bus(1, 1, 0, 4'h6, 16'h0);
        bus(1, 1, 0, 4'h8, 16'h0);
        bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h2, 16'h0);

        // div=1, ss on, A5 out / 3C in, status polled every cycle
        bus(1, 0, 1, 4'h6, 16'h0001);
        bus(1, 0, 1, 4'h8, 16'h0001);
        nxt_slv = 8'h3C;
        bus(1, 0, 1, 4'h0, 16'h00A5);
        for (int i = 0; i < 36; i++) bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h2, 16'h0);

        // overrun: second write while busy
        nxt_slv = 8'($urandom);
        bus(1, 0, 1, 4'h0, 16'h0055);
        bus(1, 0, 1, 4'h0, 16'h00FF);
        bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h2, 16'h0);
        idle(36);
        bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h2, 16'h0);

        // div=0, div write while busy ignored
        bus(1, 0, 1, 4'h6, 16'h0000);
        nxt_slv = 8'($urandom);
        bus(1, 0, 1, 4'h0, 16'h00FF);
        bus(1, 0, 1, 4'h6, 16'h0005);
        for (int i = 0; i < 20; i++) bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h6, 16'h0);
        bus(1, 1, 0, 4'h2, 16'h0);

        // reset mid-transfer, then a clean transfer at default div
        bus(1, 0, 1, 4'h6, 16'h0001);
        nxt_slv = 8'($urandom);
        bus(1, 0, 1, 4'h0, 16'h00C3);
        idle(16);
        do_reset(2);
        bus(1, 1, 0, 4'h2, 16'h0);
        bus(1, 1, 0, 4'h6, 16'h0);
        bus(1, 0, 1, 4'h8, 16'h0001);
        nxt_slv = 8'($urandom);
        bus(1, 0, 1, 4'h0, 16'h0081);
        idle(215);
        bus(1, 1, 0, 4'h2, 16'h0);
        bus(1, 1, 0, 4'h4, 16'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int k;
            k = $urandom_range(0, 15);
            nxt_slv = 8'($urandom);
            case (k)
                0: bus(1, 0, 1, 4'h0, 16'($urandom));
                1: bus(1, 1, 0, 4'h2, 16'h0);
                2: bus(1, 1, 0, 4'h4, 16'h0);
                3: bus(1, 0, 1, 4'h6, {8'($urandom), 8'($urandom_range(0, 3))});
                4: bus(1, 1, 0, 4'h6, 16'h0);
                5: bus(1, 0, 1, 4'h8, 16'($urandom));
                6: bus(1, 1, 0, 4'h8, 16'h0);
                7: begin
                    do ua = 4'($urandom);
                    while (ua == 4'h0 || ua == 4'h2 || ua == 4'h4 || ua == 4'h6 || ua == 4'h8);
                    if ($urandom_range(0, 1) == 1) bus(1, 1, 0, ua, 16'h0);
                    else bus(1, 0, 1, ua, 16'($urandom));
                end
                8: bus(0, 1, 1, 4'($urandom), 16'($urandom));
                default: idle(1);
            endcase
        end
        idle(80);
        bus(1, 1, 0, 4'h2, 16'h0);
        bus(1, 1, 0, 4'h4, 16'h0);
        bus(1, 1, 0, 4'h6, 16'h0);
        idle(2);
        chk("tx_frames_left", 16'(tx_q.size()), 16'h0);
        chk("reads_left", 16'(rd_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
